// File: rtl/Types.sv
// Shared type definitions for the memory-side blocks of the CPU.
package Types;

   typedef logic [31:0] uint32_t;
   typedef uint32_t     word;

   typedef enum logic [1:0] {
      IDLE,
      OWN_I,
      OWN_D
   } arb_state_t;

   typedef enum logic {
      OWNER_I,
      OWNER_D
   } arb_owner_t;

endpackage

// File: rtl/arb_watchdog.sv
// Saturating stall counter with a sticky expiry flag; cleared at the start of each ownership.
module arb_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   localparam int unsigned     CntW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

   logic [CntW-1:0] count, count_next;
   logic            expired_q;

   always_comb begin
      count_next = count;
      if (clear) begin
         count_next = '0;
      end else if (tick && (count != Limit)) begin
         count_next = count + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count     <= '0;
         expired_q <= 1'b0;
      end else begin
         count <= count_next;
         if (count_next == Limit) begin
            expired_q <= 1'b1;
         end
      end
   end

   assign expired = expired_q;

endmodule

// File: rtl/avalon_mm_arbiter.sv
// Two-to-one Avalon-MM arbiter (fetch vs load/store) with a stall watchdog.
// Define AVALON_ARB_ROUND_ROBIN_EN for alternating priority on conflict; default is data-first.
module avalon_mm_arbiter
   import Types::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_address,
   input  logic        i_read,
   output logic [31:0] i_readdata,
   output logic        i_waitrequest,
   input  logic [31:0] d_address,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [3:0]  d_byteenable,
   input  logic [31:0] d_writedata,
   output logic [31:0] d_readdata,
   output logic        d_waitrequest,
   output logic [31:0] m_address,
   output logic        m_read,
   output logic        m_write,
   output logic [3:0]  m_byteenable,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata,
   input  logic        m_waitrequest,
   output logic        grant_i,
   output logic        grant_d,
   output logic        timeout_err
);

   arb_state_t state, state_next;
   logic       i_req, d_req, pick_d;
   logic       wd_clear, wd_tick;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

`ifdef AVALON_ARB_ROUND_ROBIN_EN
   arb_owner_t last_owner;

   always_comb begin
      pick_d = d_req;
      if (i_req && d_req) begin
         pick_d = (last_owner == OWNER_I);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_owner <= OWNER_I;
      end else if ((state == IDLE) && (state_next != IDLE)) begin
         last_owner <= pick_d ? OWNER_D : OWNER_I;
      end
   end
`else
   assign pick_d = d_req;
`endif

   // Any owned cycle without a wait (or with the strobe gone) ends the transfer.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (i_req || d_req) state_next = pick_d ? OWN_D : OWN_I;
         OWN_I:   if (!i_req || !m_waitrequest) state_next = IDLE;
         OWN_D:   if (!d_req || !m_waitrequest) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         grant_i <= 1'b0;
         grant_d <= 1'b0;
      end else begin
         state   <= state_next;
         grant_i <= (state_next == OWN_I);
         grant_d <= (state_next == OWN_D);
      end
   end

   assign wd_clear = (state == IDLE) && (state_next != IDLE);
   assign wd_tick  = (state != IDLE) && m_waitrequest;

   arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .tick    (wd_tick),
      .expired (timeout_err)
   );

   always_comb begin
      m_address     = '0;
      m_read        = 1'b0;
      m_write       = 1'b0;
      m_byteenable  = '0;
      m_writedata   = '0;
      i_readdata    = '0;
      i_waitrequest = 1'b1;
      d_readdata    = '0;
      d_waitrequest = 1'b1;
      case (state)
         OWN_I: begin
            m_address     = i_address;
            m_read        = i_read;
            // Fetches are always full-word reads.
            m_byteenable  = 4'hF;
            i_waitrequest = m_waitrequest;
            i_readdata    = m_readdata;
         end
         OWN_D: begin
            m_address     = d_address;
            m_read        = d_read;
            m_write       = d_write;
            m_byteenable  = d_byteenable;
            m_writedata   = d_writedata;
            d_waitrequest = m_waitrequest;
            d_readdata    = m_readdata;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Self-checking bench for avalon_mm_arbiter: directed scenarios plus randomized traffic vs a model.
module tb_avalon_mm_arbiter;

   localparam int unsigned TO = 8;
`ifdef AVALON_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] i_address = '0, d_address = '0, d_writedata = '0, m_readdata = '0;
   logic        i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, m_waitrequest = 1'b0;
   logic [3:0]  d_byteenable = '0;
   logic [31:0] i_readdata, d_readdata, m_address, m_writedata;
   logic        i_waitrequest, d_waitrequest, m_read, m_write;
   logic [3:0]  m_byteenable;
   logic        grant_i, grant_d, timeout_err;

   always #5 clk = ~clk;

   avalon_mm_arbiter #(
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_address     (i_address),
      .i_read        (i_read),
      .i_readdata    (i_readdata),
      .i_waitrequest (i_waitrequest),
      .d_address     (d_address),
      .d_read        (d_read),
      .d_write       (d_write),
      .d_byteenable  (d_byteenable),
      .d_writedata   (d_writedata),
      .d_readdata    (d_readdata),
      .d_waitrequest (d_waitrequest),
      .m_address     (m_address),
      .m_read        (m_read),
      .m_write       (m_write),
      .m_byteenable  (m_byteenable),
      .m_writedata   (m_writedata),
      .m_readdata    (m_readdata),
      .m_waitrequest (m_waitrequest),
      .grant_i       (grant_i),
      .grant_d       (grant_d),
      .timeout_err   (timeout_err)
   );

   always @(posedge clk) begin
      assert (!(d_read && d_write)) else $error("illegal data request: read and write together");
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: who owns the port (0 none, 1 fetch, 2 data), conflict history, watchdog.
   int          own;
   bit          last_d;
   int unsigned wd_cnt;
   bit          wd_err;

   task automatic model_reset();
      own    = 0;
      last_d = 1'b0;
      wd_cnt = 0;
      wd_err = 1'b0;
   endtask

   task automatic model_next();
      int nxt = own;
      bit ir  = i_read;
      bit dr  = d_read | d_write;
      if (own == 0) begin
         if (ir && dr)  nxt = (RR && last_d) ? 1 : 2;
         else if (dr)   nxt = 2;
         else if (ir)   nxt = 1;
         if (nxt != 0) begin
            last_d = (nxt == 2);
            wd_cnt = 0;
         end
      end else begin
         bit strobe = (own == 1) ? ir : dr;
         if (m_waitrequest && wd_cnt < TO) begin
            wd_cnt++;
            if (wd_cnt == TO) wd_err = 1'b1;
         end
         if (!strobe || !m_waitrequest) nxt = 0;
      end
      own = nxt;
   endtask

   task automatic check_all();
      logic [31:0] e_addr, e_wdata, e_ird, e_drd;
      logic [3:0]  e_be;
      logic        e_rd, e_wr, e_iw, e_dw;
      e_addr = '0; e_wdata = '0; e_ird = '0; e_drd = '0; e_be = '0;
      e_rd = 1'b0; e_wr = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
      if (own == 1) begin
         e_addr = i_address; e_rd = i_read; e_be = 4'hF;
         e_iw = m_waitrequest; e_ird = m_readdata;
      end else if (own == 2) begin
         e_addr = d_address; e_rd = d_read; e_wr = d_write; e_be = d_byteenable;
         e_wdata = d_writedata; e_dw = m_waitrequest; e_drd = m_readdata;
      end
      check_eq("m_address", m_address, e_addr);
      check_eq("m_read", 32'(m_read), 32'(e_rd));
      check_eq("m_write", 32'(m_write), 32'(e_wr));
      check_eq("m_byteenable", 32'(m_byteenable), 32'(e_be));
      check_eq("m_writedata", m_writedata, e_wdata);
      check_eq("i_waitrequest", 32'(i_waitrequest), 32'(e_iw));
      check_eq("i_readdata", i_readdata, e_ird);
      check_eq("d_waitrequest", 32'(d_waitrequest), 32'(e_dw));
      check_eq("d_readdata", d_readdata, e_drd);
      check_eq("grant_i", 32'(grant_i), 32'(own == 1));
      check_eq("grant_d", 32'(grant_d), 32'(own == 2));
      check_eq("timeout_err", 32'(timeout_err), 32'(wd_err));
   endtask

   task automatic settle();
      #2;
      check_all();
   endtask

   task automatic adv();
      model_next();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; m_waitrequest = 1'b0;
      i_address = '0; d_address = '0; d_writedata = '0; d_byteenable = '0; m_readdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      model_reset();
      settle();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int stall_pct;
      do_reset();

      // Single fetch, zero-wait memory.
      i_read = 1'b1; i_address = 32'h100; m_readdata = 32'hDEADBEEF;
      settle(); check_eq("fetch_c0_iwait", 32'(i_waitrequest), 32'd1); adv();
      settle();
      check_eq("fetch_c1_mread", 32'(m_read), 32'd1);
      check_eq("fetch_c1_addr", m_address, 32'h100);
      check_eq("fetch_c1_iwait", 32'(i_waitrequest), 32'd0);
      check_eq("fetch_c1_rdata", i_readdata, 32'hDEADBEEF);
      adv();
      i_read = 1'b0;
      settle(); check_eq("fetch_c2_idle", 32'(grant_i), 32'd0); adv();

      // Conflict: data write wins, fetch follows after the bubble.
      i_read = 1'b1; i_address = 32'h300;
      d_write = 1'b1; d_address = 32'h200; d_writedata = 32'h12345678; d_byteenable = 4'hF;
      settle(); check_eq("conf_c0_iwait", 32'(i_waitrequest), 32'd1); adv();
      settle();
      check_eq("conf_c1_mwrite", 32'(m_write), 32'd1);
      check_eq("conf_c1_addr", m_address, 32'h200);
      check_eq("conf_c1_wdata", m_writedata, 32'h12345678);
      check_eq("conf_c1_dwait", 32'(d_waitrequest), 32'd0);
      check_eq("conf_c1_iwait", 32'(i_waitrequest), 32'd1);
      adv();
      d_write = 1'b0;
      settle(); check_eq("conf_c2_iwait", 32'(i_waitrequest), 32'd1); adv();
      settle();
      check_eq("conf_c3_granti", 32'(grant_i), 32'd1);
      check_eq("conf_c3_addr", m_address, 32'h300);
      adv();
      i_read = 1'b0;
      settle(); adv();

      // Continuous requests from both sides: grant order per policy.
      do_reset();
      i_read = 1'b1; d_read = 1'b1; i_address = 32'h40; d_address = 32'h80;
      for (int k = 0; k < 6; k++) begin
         settle(); adv();
         settle();
         check_eq("order_grant_d", 32'(grant_d), RR ? 32'((k % 2) == 0) : 32'd1);
         adv();
      end
      clear_inputs();
      settle(); adv();

      // Memory waitstates on a data read.
      d_read = 1'b1; d_address = 32'h400; m_readdata = 32'hCAFEF00D; m_waitrequest = 1'b1;
      settle(); adv();
      for (int c = 1; c <= 3; c++) begin
         settle();
         check_eq("ws_dwait", 32'(d_waitrequest), 32'd1);
         check_eq("ws_addr", m_address, 32'h400);
         adv();
      end
      m_waitrequest = 1'b0;
      settle();
      check_eq("ws_c4_dwait", 32'(d_waitrequest), 32'd0);
      check_eq("ws_c4_rdata", d_readdata, 32'hCAFEF00D);
      adv();
      d_read = 1'b0;
      settle(); check_eq("ws_idle", 32'(grant_d), 32'd0); adv();

      // Watchdog: stuck memory.
      d_read = 1'b1; d_address = 32'h600; m_waitrequest = 1'b1;
      settle(); adv();
      for (int c = 1; c <= 10; c++) begin
         settle();
         check_eq("wd_err", 32'(timeout_err), 32'(c > int'(TO)));
         adv();
      end
      m_waitrequest = 1'b0;
      settle(); check_eq("wd_sticky", 32'(timeout_err), 32'd1); adv();
      d_read = 1'b0;
      settle(); check_eq("wd_sticky_idle", 32'(timeout_err), 32'd1); adv();

      // Reset in the middle of a stalled write.
      d_write = 1'b1; d_address = 32'h500; d_writedata = 32'hA5A5A5A5; m_waitrequest = 1'b1;
      settle(); adv();
      settle(); check_eq("rst_pre_mwrite", 32'(m_write), 32'd1);
      rst = 1'b0;
      #1;
      model_reset();
      check_eq("rst_mwrite", 32'(m_write), 32'd0);
      check_eq("rst_dwait", 32'(d_waitrequest), 32'd1);
      check_eq("rst_iwait", 32'(i_waitrequest), 32'd1);
      check_eq("rst_err", 32'(timeout_err), 32'd0);
      @(negedge clk);
      d_write = 1'b0; m_waitrequest = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      settle(); check_eq("rst_post_grantd", 32'(grant_d), 32'd0); adv();

      // Randomized traffic, with stall density varying per block.
      for (int blk = 0; blk < 4; blk++) begin
         stall_pct = (blk == 0) ? 15 : (blk == 1) ? 50 : (blk == 2) ? 90 : 30;
         for (int n = 0; n < 100; n++) begin
            int sel;
            i_read        = ($urandom_range(0, 99) < 60);
            sel           = int'($urandom_range(0, 3));
            d_read        = (sel == 1);
            d_write       = (sel == 2);
            i_address     = $urandom;
            d_address     = $urandom;
            d_writedata   = $urandom;
            d_byteenable  = 4'($urandom_range(0, 15));
            m_readdata    = $urandom;
            m_waitrequest = (int'($urandom_range(0, 99)) < stall_pct);
            settle();
            adv();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
